// File: rtl/sram_frame_arbiter.sv
// Single-port ZBT SRAM controller shared by capture, random-access and display clients.
// Owns NUM_BUFS frame buffers whose roles rotate on every frame_flag.
module sram_frame_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 36,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int NUM_BUFS = 4,
  parameter int RD_LAT   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_flag,
  input  logic              disp_vsync,
  input  logic              capt_valid,
  input  logic [DATA_W-1:0] capt_data,
  output logic              capt_ready,
  output logic              capt_overflow,
  input  logic              pa_req,
  input  logic              pa_we,
  input  logic [X_W-1:0]    pa_x,
  input  logic [Y_W-1:0]    pa_y,
  input  logic [DATA_W-1:0] pa_wdata,
  output logic              pa_ack,
  output logic [DATA_W-1:0] pa_rdata,
  output logic              pa_rvalid,
  input  logic              disp_req,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we_b,
  output logic              sram_oe_b,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_oe,
  input  logic [DATA_W-1:0] sram_din
);

  localparam int FRAME = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam int BW    = $clog2(NUM_BUFS);
  localparam logic [CNT_W-1:0] FRAME_C = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(FRAME - 1);
  localparam logic [1:0] CL_CAPT = 2'd0;
  localparam logic [1:0] CL_PA   = 2'd1;
  localparam logic [1:0] CL_DISP = 2'd2;

  function automatic logic [ADDR_W-1:0] base_of(input logic [BW-1:0] b);
    return ADDR_W'(64'(b) * 64'(FRAME));
  endfunction

  logic [BW-1:0]     capt_buf, proc_buf, next_buf, disp_buf;
  logic [CNT_W-1:0]  capt_cnt, disp_cnt, disp_cur, disp_nxt;
  logic              disp_g, capt_g, pa_g, capt_full, capt_wr;
  logic              g_valid, g_we;
  logic [1:0]        g_client;
  logic [ADDR_W-1:0] g_addr, pa_off;
  logic [DATA_W-1:0] g_wdata;

  // Per-stage transaction tags; stage k is live k+1 cycles after the grant.
  logic              t_valid  [0:RD_LAT];
  logic              t_we     [0:RD_LAT];
  logic [1:0]        t_client [0:RD_LAT];
  logic [DATA_W-1:0] t_wdata  [0:RD_LAT-1];

  assign capt_ready = capt_g;
  assign pa_ack     = pa_g;

  // Fixed-priority grant and address generation for the current cycle.
  always_comb begin
    disp_g    = ~reset & disp_req;
    capt_g    = ~reset & ~disp_req & capt_valid;
    pa_g      = ~reset & ~disp_req & ~capt_valid & pa_req;
    capt_full = (capt_cnt == FRAME_C);
    capt_wr   = capt_g & ~capt_full;
    disp_cur  = disp_vsync ? '0 : disp_cnt;
    if (disp_g) begin
      disp_nxt = (disp_cur == LAST_C) ? '0 : disp_cur + CNT_W'(1);
    end else begin
      disp_nxt = disp_cur;
    end
    pa_off   = ADDR_W'(32'(pa_y) * 32'(IMG_W) + 32'(pa_x));
    g_valid  = 1'b0;
    g_we     = 1'b0;
    g_client = CL_CAPT;
    g_addr   = '0;
    g_wdata  = '0;
    if (disp_g) begin
      g_valid  = 1'b1;
      g_client = CL_DISP;
      g_addr   = base_of(disp_buf) + ADDR_W'(disp_cur);
    end else if (capt_g) begin
      g_valid  = capt_wr;
      g_we     = 1'b1;
      g_client = CL_CAPT;
      g_addr   = base_of(capt_buf) + ADDR_W'(capt_cnt);
      g_wdata  = capt_data;
    end else if (pa_g) begin
      g_valid  = 1'b1;
      g_we     = pa_we;
      g_client = CL_PA;
      g_addr   = base_of(proc_buf) + pa_off;
      g_wdata  = pa_wdata;
    end else begin
      g_valid  = 1'b0;
    end
  end

  // Buffer roles, frame counters and the SRAM command register.
  always_ff @(posedge clock) begin
    if (reset) begin
      capt_buf      <= BW'(0);
      proc_buf      <= BW'(1);
      next_buf      <= BW'(2);
      disp_buf      <= BW'(3);
      capt_cnt      <= '0;
      disp_cnt      <= '0;
      capt_overflow <= 1'b0;
      sram_addr     <= '0;
      sram_we_b     <= 1'b1;
    end else begin
      if (frame_flag) begin
        proc_buf <= capt_buf;
        next_buf <= proc_buf;
        disp_buf <= next_buf;
        capt_buf <= disp_buf;
        capt_cnt <= '0;
      end else if (capt_wr) begin
        capt_cnt <= capt_cnt + CNT_W'(1);
      end
      disp_cnt      <= disp_nxt;
      capt_overflow <= capt_g & capt_full;
      if (g_valid) begin
        sram_addr <= g_addr;
      end
      sram_we_b <= ~(g_valid & g_we);
    end
  end

  // Tag pipeline plus the data-phase drive and read-data capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k <= RD_LAT; k++) begin
        t_valid[k]  <= 1'b0;
        t_we[k]     <= 1'b0;
        t_client[k] <= CL_CAPT;
      end
      for (int k = 0; k < RD_LAT; k++) begin
        t_wdata[k] <= '0;
      end
      sram_dout    <= '0;
      sram_dout_oe <= 1'b0;
      sram_oe_b    <= 1'b1;
      pa_rdata     <= '0;
      pa_rvalid    <= 1'b0;
      disp_data    <= '0;
      disp_valid   <= 1'b0;
    end else begin
      t_valid[0]  <= g_valid;
      t_we[0]     <= g_we;
      t_client[0] <= g_client;
      t_wdata[0]  <= g_wdata;
      for (int k = 1; k <= RD_LAT; k++) begin
        t_valid[k]  <= t_valid[k-1];
        t_we[k]     <= t_we[k-1];
        t_client[k] <= t_client[k-1];
      end
      for (int k = 1; k < RD_LAT; k++) begin
        t_wdata[k] <= t_wdata[k-1];
      end
      sram_dout_oe <= t_valid[RD_LAT-1] & t_we[RD_LAT-1];
      sram_oe_b    <= ~(t_valid[RD_LAT-1] & ~t_we[RD_LAT-1]);
      if (t_valid[RD_LAT-1] & t_we[RD_LAT-1]) begin
        sram_dout <= t_wdata[RD_LAT-1];
      end
      pa_rvalid  <= t_valid[RD_LAT] & ~t_we[RD_LAT] & (t_client[RD_LAT] == CL_PA);
      disp_valid <= t_valid[RD_LAT] & ~t_we[RD_LAT] & (t_client[RD_LAT] == CL_DISP);
      if (t_valid[RD_LAT] & ~t_we[RD_LAT] & (t_client[RD_LAT] == CL_PA)) begin
        pa_rdata <= sram_din;
      end
      if (t_valid[RD_LAT] & ~t_we[RD_LAT] & (t_client[RD_LAT] == CL_DISP)) begin
        disp_data <= sram_din;
      end
    end
  end

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Directed bench for sram_frame_arbiter on a small 8x4 image with a 2-stage ZBT model.
// Buffer bases are 0/32/64/96; untouched SRAM words hold 16'hA000 + address.
module tb_sram_frame_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_flag = 1'b0, disp_vsync = 1'b0;
  logic        capt_valid = 1'b0, capt_ready, capt_overflow;
  logic [15:0] capt_data = 16'h0;
  logic        pa_req = 1'b0, pa_we = 1'b0, pa_ack, pa_rvalid;
  logic [3:0]  pa_x = 4'h0, pa_y = 4'h0;
  logic [15:0] pa_wdata = 16'h0, pa_rdata;
  logic        disp_req = 1'b0, disp_valid;
  logic [15:0] disp_data;
  logic [7:0]  sram_addr;
  logic        sram_we_b, sram_oe_b, sram_dout_oe;
  logic [15:0] sram_dout, sram_din;

  sram_frame_arbiter #(.ADDR_W(8), .DATA_W(16), .IMG_W(8), .IMG_H(4), .X_W(4), .Y_W(4),
                       .NUM_BUFS(4), .RD_LAT(2)) dut (
    .clock(clock), .reset(reset), .frame_flag(frame_flag), .disp_vsync(disp_vsync),
    .capt_valid(capt_valid), .capt_data(capt_data), .capt_ready(capt_ready),
    .capt_overflow(capt_overflow), .pa_req(pa_req), .pa_we(pa_we), .pa_x(pa_x),
    .pa_y(pa_y), .pa_wdata(pa_wdata), .pa_ack(pa_ack), .pa_rdata(pa_rdata),
    .pa_rvalid(pa_rvalid), .disp_req(disp_req), .disp_data(disp_data),
    .disp_valid(disp_valid), .sram_addr(sram_addr), .sram_we_b(sram_we_b),
    .sram_oe_b(sram_oe_b), .sram_dout(sram_dout), .sram_dout_oe(sram_dout_oe),
    .sram_din(sram_din));

  always #5 clock = ~clock;

  int total = 0, bad = 0, cyc = 0, ovf_cnt = 0;
  logic [15:0] mem [0:255];
  logic [7:0]  p1a = 8'h0, p2a = 8'h0;
  logic [7:0]  wa_q[$];
  logic [15:0] wd_q[$], pa_q[$], disp_q[$];
  int          pa_cq[$], disp_cq[$];

  initial for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);

  // ZBT model: the address of cycle t is in its data phase during cycle t+2.
  assign sram_din = mem[p2a];
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (sram_dout_oe) begin
      mem[p2a] <= sram_dout;
      wa_q.push_back(p2a);
      wd_q.push_back(sram_dout);
    end
    p2a <= p1a;
    p1a <= sram_addr;
  end

  always @(negedge clock) begin
    if (pa_rvalid) begin pa_q.push_back(pa_rdata); pa_cq.push_back(cyc); end
    if (disp_valid) begin disp_q.push_back(disp_data); disp_cq.push_back(cyc); end
    if (capt_overflow) ovf_cnt++;
  end

  task automatic tick(); @(posedge clock); #1; endtask
  task automatic settle(); #2; endtask

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); pa_q.delete(); pa_cq.delete();
    disp_q.delete(); disp_cq.delete(); ovf_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_flag = 1'b0; disp_vsync = 1'b0; capt_valid = 1'b0;
    pa_req = 1'b0; pa_we = 1'b0; disp_req = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    reset = 1'b1; capt_valid = 1'b1; pa_req = 1'b1; disp_req = 1'b1;
    repeat (3) tick();
    settle();
    total++; if (capt_ready !== 1'b0) begin bad++; $display("FAIL rst_capt_ready: got %b want 0", capt_ready); end
    total++; if (pa_ack !== 1'b0) begin bad++; $display("FAIL rst_pa_ack: got %b want 0", pa_ack); end
    total++; if (sram_we_b !== 1'b1) begin bad++; $display("FAIL rst_we_b: got %b want 1", sram_we_b); end
    total++; if (sram_oe_b !== 1'b1) begin bad++; $display("FAIL rst_oe_b: got %b want 1", sram_oe_b); end
    total++; if (sram_addr !== 8'h00) begin bad++; $display("FAIL rst_addr: got %h want 00", sram_addr); end
    total++; if ({sram_dout_oe, capt_overflow, pa_rvalid, disp_valid} !== 4'b0000) begin
      bad++; $display("FAIL rst_strobes: got %b want 0000", {sram_dout_oe, capt_overflow, pa_rvalid, disp_valid});
    end
    do_reset();
  endtask

  task automatic test_capture();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      capt_valid = 1'b1; capt_data = 16'h0100 + 16'(i);
      settle();
      total++; if (capt_ready !== 1'b1) begin bad++; $display("FAIL capt_ready[%0d]: got %b want 1", i, capt_ready); end
      if (i == 1) begin
        total++; if ({sram_addr, sram_we_b} !== {8'h00, 1'b0}) begin
          bad++; $display("FAIL capt_cmd: got addr %h we_b %b want 00/0", sram_addr, sram_we_b);
        end
      end
      tick();
    end
    capt_valid = 1'b0;
    repeat (5) tick();
    total++; if (wa_q.size() != 8) begin bad++; $display("FAIL capt_nwrites: got %0d want 8", wa_q.size()); end
    for (int i = 0; i < 8 && i < wa_q.size(); i++) begin
      total++; if (wa_q[i] !== 8'(i) || wd_q[i] !== 16'h0100 + 16'(i)) begin
        bad++; $display("FAIL capt_write[%0d]: got %h@%h want %h@%h", i, wd_q[i], wa_q[i], 16'h0100 + 16'(i), 8'(i));
      end
    end
  endtask

  task automatic test_pa();
    int ack_c;
    do_reset();
    pa_req = 1'b1; pa_we = 1'b0; pa_x = 4'd3; pa_y = 4'd1;
    settle();
    total++; if (pa_ack !== 1'b1) begin bad++; $display("FAIL pa_ack: got %b want 1", pa_ack); end
    ack_c = cyc;
    tick(); pa_req = 1'b0; settle();
    total++; if ({sram_addr, sram_we_b} !== {8'd43, 1'b1}) begin
      bad++; $display("FAIL pa_rd_cmd: got addr %0d we_b %b want 43/1", sram_addr, sram_we_b);
    end
    repeat (6) tick();
    total++; if (pa_q.size() != 1) begin bad++; $display("FAIL pa_rd_count: got %0d want 1", pa_q.size()); end
    if (pa_q.size() > 0) begin
      total++; if (pa_q[0] !== 16'hA02B) begin bad++; $display("FAIL pa_rdata: got %h want a02b", pa_q[0]); end
      total++; if (pa_cq[0] - ack_c != 4) begin bad++; $display("FAIL pa_latency: got %0d want 4", pa_cq[0] - ack_c); end
    end
    // After one rotation proc is buffer 0: write then read back-to-back.
    frame_flag = 1'b1; tick(); frame_flag = 1'b0;
    clear_logs();
    pa_req = 1'b1; pa_we = 1'b1; pa_x = 4'd5; pa_y = 4'd0; pa_wdata = 16'h7777;
    tick(); pa_we = 1'b0; tick(); pa_req = 1'b0;
    repeat (7) tick();
    total++; if (wa_q.size() != 1 || wa_q[0] !== 8'd5 || wd_q[0] !== 16'h7777) begin
      bad++; $display("FAIL pa_write: got %0d writes first %h@%h want 7777@05", wa_q.size(), wd_q[0], wa_q[0]);
    end
    total++; if (pa_q.size() != 1 || pa_q[0] !== 16'h7777) begin
      bad++; $display("FAIL pa_b2b_read: got %0d reads first %h want 7777", pa_q.size(), pa_q[0]);
    end
  endtask

  task automatic test_priority();
    int g0;
    do_reset();
    disp_req = 1'b1; capt_valid = 1'b1; capt_data = 16'h0C0C;
    pa_req = 1'b1; pa_we = 1'b1; pa_x = 4'd1; pa_y = 4'd1; pa_wdata = 16'hBEEF;
    g0 = cyc;
    for (int i = 0; i < 3; i++) begin
      settle();
      total++; if ({capt_ready, pa_ack} !== 2'b00) begin
        bad++; $display("FAIL prio_disp[%0d]: got ready/ack %b want 00", i, {capt_ready, pa_ack});
      end
      tick();
    end
    disp_req = 1'b0; settle();
    total++; if ({capt_ready, pa_ack} !== 2'b10) begin bad++; $display("FAIL prio_capt: got %b want 10", {capt_ready, pa_ack}); end
    tick(); capt_valid = 1'b0; settle();
    total++; if ({capt_ready, pa_ack} !== 2'b01) begin bad++; $display("FAIL prio_pa: got %b want 01", {capt_ready, pa_ack}); end
    tick(); pa_req = 1'b0; pa_we = 1'b0;
    repeat (6) tick();
    total++; if (disp_q.size() != 3) begin bad++; $display("FAIL prio_disp_count: got %0d want 3", disp_q.size()); end
    for (int i = 0; i < 3 && i < disp_q.size(); i++) begin
      total++; if (disp_q[i] !== 16'hA060 + 16'(i)) begin bad++; $display("FAIL prio_disp_data[%0d]: got %h want %h", i, disp_q[i], 16'hA060 + 16'(i)); end
    end
    if (disp_cq.size() > 0) begin
      total++; if (disp_cq[0] - g0 != 4) begin bad++; $display("FAIL disp_latency: got %0d want 4", disp_cq[0] - g0); end
    end
    total++; if (wa_q.size() != 2 || wa_q[0] !== 8'd0 || wd_q[0] !== 16'h0C0C || wa_q[1] !== 8'd41 || wd_q[1] !== 16'hBEEF) begin
      bad++; $display("FAIL prio_writes: got %0d writes %h@%h %h@%h want 0c0c@00 beef@29", wa_q.size(), wd_q[0], wa_q[0], wd_q[1], wa_q[1]);
    end
  endtask

  task automatic test_display();
    logic [15:0] exp_v [0:3];
    do_reset();
    disp_req = 1'b1; repeat (33) tick(); disp_req = 1'b0;
    repeat (6) tick();
    total++; if (disp_q.size() != 33) begin bad++; $display("FAIL disp_count: got %0d want 33", disp_q.size()); end
    if (disp_q.size() == 33) begin
      total++; if (disp_q[31] !== 16'hA07F || disp_q[32] !== 16'hA060) begin
        bad++; $display("FAIL disp_wrap: got %h,%h want a07f,a060", disp_q[31], disp_q[32]);
      end
    end
    clear_logs();
    disp_req = 1'b1; tick(); tick();
    disp_vsync = 1'b1; tick(); disp_vsync = 1'b0; tick(); disp_req = 1'b0;
    repeat (6) tick();
    exp_v[0] = 16'hA061; exp_v[1] = 16'hA062; exp_v[2] = 16'hA060; exp_v[3] = 16'hA061;
    total++; if (disp_q.size() != 4) begin bad++; $display("FAIL vsync_count: got %0d want 4", disp_q.size()); end
    for (int i = 0; i < 4 && i < disp_q.size(); i++) begin
      total++; if (disp_q[i] !== exp_v[i]) begin bad++; $display("FAIL vsync_data[%0d]: got %h want %h", i, disp_q[i], exp_v[i]); end
    end
  endtask

  task automatic test_overflow();
    int nready = 0, hit_end = 0;
    do_reset();
    for (int i = 0; i < 33; i++) begin
      capt_valid = 1'b1; capt_data = 16'h0200 + 16'(i);
      settle();
      if (capt_ready === 1'b1) nready++;
      tick();
    end
    capt_valid = 1'b0;
    repeat (5) tick();
    foreach (wa_q[i]) if (wa_q[i] == 8'd32) hit_end++;
    total++; if (nready != 33) begin bad++; $display("FAIL ovf_ready: got %0d want 33", nready); end
    total++; if (wa_q.size() != 32) begin bad++; $display("FAIL ovf_writes: got %0d want 32", wa_q.size()); end
    if (wa_q.size() > 0) begin
      total++; if (wa_q[wa_q.size()-1] !== 8'd31 || wd_q[wd_q.size()-1] !== 16'h021F) begin
        bad++; $display("FAIL ovf_last: got %h@%h want 021f@1f", wd_q[wd_q.size()-1], wa_q[wa_q.size()-1]);
      end
    end
    total++; if (hit_end != 0) begin bad++; $display("FAIL ovf_end_write: got %0d want 0", hit_end); end
    total++; if (ovf_cnt != 1) begin bad++; $display("FAIL ovf_pulses: got %0d want 1", ovf_cnt); end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      capt_valid = 1'b1; capt_data = 16'h0C00 + 16'(i); frame_flag = (i == 4);
      tick();
    end
    capt_valid = 1'b0; frame_flag = 1'b0; tick();
    frame_flag = 1'b1; tick(); frame_flag = 1'b0; tick();
    frame_flag = 1'b1; tick(); frame_flag = 1'b0;
    repeat (4) tick();
    total++; if (wa_q.size() != 5 || wa_q[4] !== 8'd4) begin
      bad++; $display("FAIL rot_flag_grant: got %0d writes last addr %h want 5 at 04", wa_q.size(), wa_q[wa_q.size()-1]);
    end
    clear_logs();
    disp_req = 1'b1; repeat (4) tick(); disp_req = 1'b0;
    repeat (6) tick();
    total++; if (disp_q.size() != 4) begin bad++; $display("FAIL rot_disp_count: got %0d want 4", disp_q.size()); end
    for (int i = 0; i < 4 && i < disp_q.size(); i++) begin
      total++; if (disp_q[i] !== 16'h0C00 + 16'(i)) begin bad++; $display("FAIL rot_disp[%0d]: got %h want %h", i, disp_q[i], 16'h0C00 + 16'(i)); end
    end
    frame_flag = 1'b1; tick(); frame_flag = 1'b0;
    clear_logs();
    capt_valid = 1'b1; capt_data = 16'h0D00; tick(); capt_valid = 1'b0;
    pa_req = 1'b1; pa_we = 1'b0; pa_x = 4'd0; pa_y = 4'd0; tick(); pa_req = 1'b0;
    disp_vsync = 1'b1; disp_req = 1'b1; tick(); disp_vsync = 1'b0; disp_req = 1'b0;
    repeat (6) tick();
    total++; if (wa_q.size() != 1 || wa_q[0] !== 8'd0 || wd_q[0] !== 16'h0D00) begin
      bad++; $display("FAIL rot4_capt: got %0d writes %h@%h want 0d00@00", wa_q.size(), wd_q[0], wa_q[0]);
    end
    total++; if (pa_q.size() != 1 || pa_q[0] !== 16'hA020) begin bad++; $display("FAIL rot4_proc: got %0d reads %h want a020", pa_q.size(), pa_q[0]); end
    total++; if (disp_q.size() != 1 || disp_q[0] !== 16'hA060) begin bad++; $display("FAIL rot4_disp: got %0d reads %h want a060", disp_q.size(), disp_q[0]); end
  endtask

  task automatic test_reset_flush();
    do_reset();
    pa_req = 1'b1; pa_we = 1'b0; pa_x = 4'd2; pa_y = 4'd2;
    settle();
    total++; if (pa_ack !== 1'b1) begin bad++; $display("FAIL flush_ack: got %b want 1", pa_ack); end
    tick(); pa_req = 1'b0; reset = 1'b1;
    tick(); reset = 1'b0; settle();
    total++; if ({sram_we_b, sram_oe_b} !== 2'b11) begin bad++; $display("FAIL flush_ctl: got %b want 11", {sram_we_b, sram_oe_b}); end
    repeat (8) tick();
    total++; if (pa_q.size() != 0) begin bad++; $display("FAIL flush_rvalid: got %0d strobes want 0", pa_q.size()); end
    total++; if (sram_oe_b !== 1'b1) begin bad++; $display("FAIL flush_oe_idle: got %b want 1", sram_oe_b); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_pa();
    test_priority();
    test_display();
    test_overflow();
    test_rotation();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
